// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one result buffer per execution requester, at most one
// registered broadcast per cycle, ROB-head entry first, otherwise round-robin.
module cdb_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [3:0]       rob_head_idx,
  input  logic [3:0]       in_valid_flat,
  input  logic [15:0]      in_rob_idx_flat,
  input  logic [63:0]      in_value_flat,
  output logic [3:0]       buf_full_flat,
  output logic             cdb_valid,
  output logic [3:0]       cdb_rob_idx,
  output logic [15:0]      cdb_value,
  output logic [1:0]       cdb_src,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int N = 4;

  logic [N-1:0]     r_buf_valid;
  logic [3:0]       r_buf_rob_idx [N];
  logic [15:0]      r_buf_value   [N];
  logic [1:0]       r_rr_ptr;
  logic             r_cdb_valid;
  logic [3:0]       r_cdb_rob_idx;
  logic [15:0]      r_cdb_value;
  logic [1:0]       r_cdb_src;
  logic [CNT_W-1:0] r_conflict_cnt;

  logic [N-1:0] w_head_hit;
  logic [N-1:0] w_grant;
  logic [N-1:0] w_buf_full;
  logic [N-1:0] w_accept;
  logic         w_grant_vld;
  logic [1:0]   w_grant_idx;
  logic         w_conflict;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_head_hit = '0;
    w_conflict = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_head_hit[i] = r_buf_valid[i] && (r_buf_rob_idx[i] == rob_head_idx);
      for (int j = i + 1; j < N; j++)
        if (r_buf_valid[i] && r_buf_valid[j]) w_conflict = 1'b1;
    end
  end

  // Loops run from the far end so the nearest candidate is assigned last and wins.
  always_comb begin
    w_grant_idx = 2'd0;
    w_grant_vld = |r_buf_valid;
    if (|w_head_hit) begin
      for (int i = N - 1; i >= 0; i--)
        if (w_head_hit[i]) w_grant_idx = 2'(i);
    end else begin
      for (int k = N - 1; k >= 0; k--)
        if (r_buf_valid[r_rr_ptr + 2'(k)]) w_grant_idx = r_rr_ptr + 2'(k);
    end
    w_grant = w_grant_vld ? (4'b0001 << w_grant_idx) : 4'b0000;
  end

  assign w_buf_full = r_buf_valid & ~w_grant;
  assign w_accept   = in_valid_flat & ~w_buf_full & {N{~flush}};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_valid    <= '0;
      r_rr_ptr       <= 2'd0;
      r_cdb_valid    <= 1'b0;
      r_cdb_rob_idx  <= 4'd0;
      r_cdb_value    <= 16'd0;
      r_cdb_src      <= 2'd0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_conflict && !(&r_conflict_cnt))
        r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
      if (flush) begin
        r_buf_valid <= '0;
        r_cdb_valid <= 1'b0;
        r_rr_ptr    <= 2'd0;
      end else begin
        r_buf_valid <= (r_buf_valid & ~w_grant) | w_accept;
        r_cdb_valid <= w_grant_vld;
        if (w_grant_vld) begin
          r_cdb_rob_idx <= r_buf_rob_idx[w_grant_idx];
          r_cdb_value   <= r_buf_value[w_grant_idx];
          r_cdb_src     <= w_grant_idx;
          r_rr_ptr      <= w_grant_idx + 2'd1;
        end
      end
    end
  end

  // NOTE: payload storage has no reset; its contents are only ever read behind r_buf_valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (w_accept[i]) begin
        r_buf_rob_idx[i] <= in_rob_idx_flat[4*i +: 4];
        r_buf_value[i]   <= in_value_flat[16*i +: 16];
      end
    end
  end

  assign buf_full_flat = w_buf_full;
  assign cdb_valid     = r_cdb_valid;
  assign cdb_rob_idx   = r_cdb_rob_idx;
  assign cdb_value     = r_cdb_value;
  assign cdb_src       = r_cdb_src;
  assign conflict_cnt  = r_conflict_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model of the arbitration rules.
module tb_cdb_arbiter;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [3:0]       rob_head_idx = 4'd0;
  logic [3:0]       in_valid_flat = 4'd0;
  logic [15:0]      in_rob_idx_flat = 16'd0;
  logic [63:0]      in_value_flat = 64'd0;
  logic [3:0]       buf_full_flat;
  logic             cdb_valid;
  logic [3:0]       cdb_rob_idx;
  logic [15:0]      cdb_value;
  logic [1:0]       cdb_src;
  logic [CNT_W-1:0] conflict_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model state
  bit m_valid [4];
  int m_rob   [4];
  int m_val   [4];
  int m_rr;
  bit m_cdb_valid;
  int m_cdb_rob, m_cdb_val, m_cdb_src, m_cnt;

  cdb_arbiter #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .rob_head_idx   (rob_head_idx),
    .in_valid_flat  (in_valid_flat),
    .in_rob_idx_flat(in_rob_idx_flat),
    .in_value_flat  (in_value_flat),
    .buf_full_flat  (buf_full_flat),
    .cdb_valid      (cdb_valid),
    .cdb_rob_idx    (cdb_rob_idx),
    .cdb_value      (cdb_value),
    .cdb_src        (cdb_src),
    .conflict_cnt   (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which requester the rules pick right now, or -1 when nothing is buffered.
  function automatic int model_grant();
    for (int i = 0; i < 4; i++)
      if (m_valid[i] && m_rob[i] == int'(rob_head_idx)) return i;
    for (int k = 0; k < 4; k++)
      if (m_valid[(m_rr + k) % 4]) return (m_rr + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] model_full();
    int g;
    logic [3:0] f;
    g = model_grant();
    f = 4'd0;
    for (int i = 0; i < 4; i++) f[i] = m_valid[i] && (g != i);
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    m_rr = 0; m_cdb_valid = 1'b0; m_cdb_rob = 0; m_cdb_val = 0; m_cdb_src = 0; m_cnt = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      int g, nv;
      logic [3:0] f;
      g  = model_grant();
      f  = model_full();
      nv = 0;
      for (int i = 0; i < 4; i++) nv += int'(m_valid[i]);
      if (nv >= 2 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (flush) begin
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        m_cdb_valid = 1'b0;
        m_rr = 0;
      end else begin
        if (g >= 0) begin
          m_cdb_valid = 1'b1;
          m_cdb_rob   = m_rob[g];
          m_cdb_val   = m_val[g];
          m_cdb_src   = g;
          m_rr        = (g + 1) % 4;
          m_valid[g]  = 1'b0;
        end else begin
          m_cdb_valid = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
          if (in_valid_flat[i] && !f[i]) begin
            m_valid[i] = 1'b1;
            m_rob[i]   = int'(in_rob_idx_flat[4*i +: 4]);
            m_val[i]   = int'(in_value_flat[16*i +: 16]);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("buf_full",     32'(buf_full_flat), 32'(model_full()));
      check("cdb_valid",    32'(cdb_valid),     32'(m_cdb_valid));
      check("cdb_rob_idx",  32'(cdb_rob_idx),   m_cdb_rob);
      check("cdb_value",    32'(cdb_value),     m_cdb_val);
      check("cdb_src",      32'(cdb_src),       m_cdb_src);
      check("conflict_cnt", 32'(conflict_cnt),  m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int i, input int rob, input int val);
    in_valid_flat[i]            = 1'b1;
    in_rob_idx_flat[4*i +: 4]   = 4'(rob);
    in_value_flat[16*i +: 16]   = 16'(val);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    check("rst_buf_full",  32'(buf_full_flat), 32'h0);
    check("rst_cdb_valid", 32'(cdb_valid),     32'h0);
    check("rst_cnt",       32'(conflict_cnt),  32'h0);

    // Single result, two-edge latency.
    rob_head_idx = 4'd0;
    push(0, 3, 'h1234);
    tick();
    in_valid_flat = 4'd0;
    tick();
    check("single_valid", 32'(cdb_valid),   32'h1);
    check("single_rob",   32'(cdb_rob_idx), 32'h3);
    check("single_value", 32'(cdb_value),   32'h1234);
    check("single_src",   32'(cdb_src),     32'h0);
    tick();
    check("single_idle",  32'(cdb_valid),   32'h0);

    // All four requesters at once: round-robin order and conflict counting.
    do_flush();
    rob_head_idx = 4'd8;
    for (int i = 0; i < 4; i++) push(i, i, 'hA000 + i);
    tick();
    in_valid_flat = 4'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_valid", 32'(cdb_valid), 32'h1);
      check("rr_src",   32'(cdb_src),   32'(k));
      check("rr_value", 32'(cdb_value), 32'hA000 + 32'(k));
    end
    check("rr_conflict", 32'(conflict_cnt), 32'd3);

    // ROB-head match jumps the queue.
    do_flush();
    rob_head_idx = 4'd5;
    push(0, 1, 'h0B00);
    push(2, 5, 'h2B00);
    tick();
    in_valid_flat = 4'd0;
    tick();
    check("head_src_first",   32'(cdb_src),   32'h2);
    check("head_value_first", 32'(cdb_value), 32'h2B00);
    tick();
    check("head_valid_second", 32'(cdb_valid), 32'h1);
    check("head_src_second",   32'(cdb_src),   32'h0);
    check("head_conflict",     32'(conflict_cnt), 32'd4);

    // Back-to-back streaming from one requester.
    do_flush();
    rob_head_idx = 4'd15;
    for (int k = 0; k <= 8; k++) begin
      in_valid_flat = 4'd0;
      if (k < 8) begin
        push(1, k, 'h100 + k);
        check("stream_full", 32'(buf_full_flat[1]), 32'h0);
      end
      tick();
      if (k >= 1) begin
        check("stream_valid", 32'(cdb_valid), 32'h1);
        check("stream_value", 32'(cdb_value), 32'h100 + 32'(k - 1));
      end
    end
    tick();
    check("stream_idle", 32'(cdb_valid), 32'h0);

    // Flush squashes buffered results and the concurrent new one.
    push(0, 0, 'h1111);
    push(1, 1, 'h2222);
    push(2, 2, 'h3333);
    tick();
    in_valid_flat = 4'd0;
    flush = 1'b1;
    push(3, 9, 'h4444);
    tick();
    flush = 1'b0;
    in_valid_flat = 4'd0;
    check("flush_full",  32'(buf_full_flat), 32'h0);
    check("flush_valid", 32'(cdb_valid),     32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("flush_quiet", 32'(cdb_valid), 32'h0);
    end
    check("flush_keeps_cnt", 32'(conflict_cnt), 32'd5);

    // Asynchronous reset between edges.
    push(0, 1, 'h5555);
    push(1, 2, 'h6666);
    tick();
    in_valid_flat = 4'd0;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_full",  32'(buf_full_flat), 32'h0);
    check("arst_valid", 32'(cdb_valid),     32'h0);
    check("arst_rob",   32'(cdb_rob_idx),   32'h0);
    check("arst_value", 32'(cdb_value),     32'h0);
    check("arst_src",   32'(cdb_src),       32'h0);
    check("arst_cnt",   32'(conflict_cnt),  32'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("arst_quiet", 32'(cdb_valid), 32'h0);
    end

    // Randomized traffic with occasional flushes, protocol violations and resets.
    repeat (3000) begin
      rob_head_idx = 4'($urandom_range(0, 7));
      flush        = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < 4; i++) begin
        in_rob_idx_flat[4*i +: 4]  = 4'($urandom_range(0, 7));
        in_value_flat[16*i +: 16]  = 16'($urandom);
      end
      in_valid_flat = 4'($urandom);
      if ($urandom_range(0, 7) != 0) in_valid_flat = in_valid_flat & ~model_full();
      if ($urandom_range(0, 999) == 0) begin
        #1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    flush         = 1'b0;
    in_valid_flat = 4'd0;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of conflict performance counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  synchronous squash (branch mispredict), active-high.
REQ-005 SHALL have port rob_head_idx  input  4  current ROB head index.
REQ-006 SHALL have port in_valid_flat  input  4  result valid per requester; bit i = requester i (0=fxu_0, 1=fxu_1, 2=lsu, 3=branch).
REQ-007 SHALL have port in_rob_idx_flat  input  16  requester i ROB index at [4i+3:4i].
REQ-008 SHALL have port in_value_flat  input  64  requester i result at [16i+15:16i].
REQ-009 SHALL have port buf_full_flat  output  4  bit i high: requester i SHALL NOT present a result this cycle.
REQ-010 SHALL have port cdb_valid  output  1  broadcast valid on common data bus.
REQ-011 SHALL have port cdb_rob_idx  output  4  broadcast ROB index.
REQ-012 SHALL have port cdb_value  output  16  broadcast result value.
REQ-013 SHALL have port cdb_src  output  2  requester number that owns the broadcast.
REQ-014 SHALL have port conflict_cnt  output  CNT_W  count of cycles with two or more buffered results.

Function
REQ-015 SHALL hold one entry per requester: buf_valid, buf_rob_idx (4b), buf_value (16b).
REQ-016 SHALL compute a grant each cycle selecting at most one requester with buf_valid=1.
REQ-017 Head priority: if any valid entry has buf_rob_idx == rob_head_idx, SHALL grant the lowest-numbered such requester.
REQ-018 Otherwise SHALL grant round-robin: first valid requester at or after rr_ptr (2b), wrapping 3->0.
REQ-019 On any grant, SHALL set rr_ptr <= granted+1 mod 4; with no grant, rr_ptr unchanged.
REQ-020 buf_full[i] SHALL equal buf_valid[i] & ~grant[i], combinational from registered state and rob_head_idx.
REQ-021 SHALL accept in_valid[i] into entry i when buf_valid[i]=0 or grant[i]=1 (same-edge drain and refill).
REQ-022 in_valid[i] while buf_full[i]=1 is a protocol violation; SHALL be ignored, entry unchanged.
REQ-023 Granted entry without simultaneous accept SHALL clear buf_valid[i] at the edge.
REQ-024 Outputs cdb_* SHALL be registered: cdb_valid <= any grant; cdb_rob_idx/value/src <= granted entry; with no grant cdb_valid <= 0 and other cdb fields hold.
REQ-025 Latency: result presented at edge N is broadcast (cdb_valid=1) after edge N+1 at earliest; one broadcast per cycle maximum.
REQ-026 conflict_cnt SHALL increment by 1 each cycle where two or more buf_valid are set, saturating at all-ones.
REQ-027 flush=1 SHALL, at the edge, clear all buf_valid, set cdb_valid <= 0, set rr_ptr <= 0, and ignore in_valid that cycle; flush beats accept and grant.
REQ-028 conflict_cnt SHALL NOT be cleared by flush.

Reset
REQ-029 rst_n=0 SHALL immediately, without clock, clear all buf_valid, rr_ptr, cdb_valid, cdb_rob_idx, cdb_value, cdb_src, conflict_cnt to 0; buf_full_flat reads 0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered results; first accept is on the first rising edge with rst_n=1.

Verification
REQ-031 Single: in_valid[0]=1, rob_idx 3, value 0x1234, head 0 at edge 0 -> after edge 1 cdb_valid=1, cdb_rob_idx=3, cdb_value=0x1234, cdb_src=0; after edge 2 cdb_valid=0.
REQ-032 Round-robin: all four push at edge 0, distinct rob_idx != head, rr_ptr=0 -> cdb_src 0,1,2,3 after edges 1..4; conflict_cnt=3.
REQ-033 Head priority: entries 0 and 2 valid, entry 2 rob_idx=5, rob_head_idx=5 -> cdb_src=2 first, then 0; rr_ptr=3 after first grant.
REQ-034 Streaming: requester 1 alone presents every cycle for 8 cycles -> buf_full[1]=0 throughout, cdb_valid=1 on 8 consecutive cycles, values in order.
REQ-035 Flush: 3 entries valid, flush=1 with in_valid[3]=1 -> next cycle buf_full_flat=0, cdb_valid=0, nothing broadcast afterwards.
REQ-036 Async reset: rst_n low between edges with 2 entries valid -> outputs 0 immediately; no broadcast after release.
